// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared pipeline constants, control bundle and decode helpers
package pipeline_hazard_ctrl_pkg;

    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_MEM_WAIT = 2'd1;
    localparam logic [1:0]  ST_HALT     = 2'd2;
    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef struct packed {
        logic pcWe;
        logic ifidWe;
        logic ifidFlush;
        logic idexWe;
        logic idexFlush;
        logic exmemWe;
        logic memwbFlush;
    } ctrl_t;

    function automatic ctrl_t ctrlAll(input logic we, input logic flush);
        ctrl_t c;
        c.pcWe       = we;
        c.ifidWe     = we;
        c.ifidFlush  = flush;
        c.idexWe     = we;
        c.idexFlush  = flush;
        c.exmemWe    = we;
        c.memwbFlush = flush;
        return c;
    endfunction

    // Everything held; only the MEM/WB stage is bubbled so a stalled access never retires twice.
    function automatic ctrl_t ctrlFrozen();
        ctrl_t c;
        c = ctrlAll(1'b0, 1'b0);
        c.memwbFlush = 1'b1;
        return c;
    endfunction

    // Normal-flow decode: redirect beats load-use, which beats plain advance.
    function automatic ctrl_t ctrlRun(input logic redirect, input logic hazard);
        ctrl_t c;
        c = ctrlAll(1'b1, 1'b0);
        if (redirect) begin
            c.ifidFlush = 1'b1;
            c.idexFlush = 1'b1;
        end else if (hazard) begin
            c.pcWe      = 1'b0;
            c.ifidWe    = 1'b0;
            c.idexFlush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard-controller bundle between pipeline datapath and sequencer
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             idex_memread;
    logic [4:0]       idex_rt;
    logic             ex_redirect;
    logic             exmem_memreq;
    logic             mem_ack;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt,
               ex_redirect, exmem_memreq, mem_ack,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, memwb_flush, mem_err, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt,
               ex_redirect, exmem_memreq, mem_ack,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, memwb_flush, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use hazard equation
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);
    // A load into r0 writes nothing, so it can never feed a dependent instruction.
    assign hazard = idex_memread && (idex_rt != REG_ZERO) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline register/PC sequencer: load-use bubbles, redirects, memory freeze
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic [WAIT_W-1:0] waitCntNext;
    logic              memErr;
    logic              memErrNext;
    logic [CNT_W-1:0]  stallCnt;
    logic              hazard;
    ctrl_t             ctrl;

    hazard_detect u_hazard_detect (
        .idex_memread (bus.idex_memread),
        .idex_rt      (bus.idex_rt),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_uses_rt   (bus.id_uses_rt),
        .hazard       (hazard)
    );

    always_comb begin
        ctrl        = ctrlAll(1'b1, 1'b0);
        nextState   = state;
        waitCntNext = waitCnt;
        memErrNext  = memErr;
        if (rst) begin
            ctrl        = ctrlAll(1'b0, 1'b1);
            nextState   = ST_RUN;
            waitCntNext = '0;
            memErrNext  = 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.exmem_memreq && !bus.mem_ack) begin
                        ctrl        = ctrlFrozen();
                        nextState   = ST_MEM_WAIT;
                        waitCntNext = WAIT_W'(1);
                    end else begin
                        ctrl = ctrlRun(bus.ex_redirect, hazard);
                    end
                end
                ST_MEM_WAIT: begin
                    // The ack cycle resumes normally; held redirects/hazards act right here.
                    if (bus.mem_ack) begin
                        ctrl        = ctrlRun(bus.ex_redirect, hazard);
                        nextState   = ST_RUN;
                        waitCntNext = '0;
                    end else begin
                        ctrl = ctrlFrozen();
                        if (waitCnt == WAIT_MAX) begin
                            nextState  = ST_HALT;
                            memErrNext = 1'b1;
                        end else begin
                            waitCntNext = waitCnt + 1'b1;
                        end
                    end
                end
                ST_HALT: ctrl = ctrlAll(1'b0, 1'b0);
                default: begin
                    ctrl      = ctrlAll(1'b0, 1'b0);
                    nextState = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state   <= nextState;
        waitCnt <= waitCntNext;
        memErr  <= memErrNext;
        if (rst) begin
            stallCnt <= '0;
        end else if (!ctrl.pcWe && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign bus.pc_we        = ctrl.pcWe;
    assign bus.ifid_we      = ctrl.ifidWe;
    assign bus.ifid_flush   = ctrl.ifidFlush;
    assign bus.idex_we      = ctrl.idexWe;
    assign bus.idex_flush   = ctrl.idexFlush;
    assign bus.exmem_we     = ctrl.exmemWe;
    assign bus.memwb_flush  = ctrl.memwbFlush;
    assign bus.mem_err      = memErr;
    assign bus.stall_cycles = stallCnt;
endmodule
